// File: rtl/muldiv_pkg.sv
// Shared types and default widths for the restoring divider.
package muldiv_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_t;

  localparam int DEF_N_W = 16;
  localparam int DEF_D_W = 8;
  localparam int CNT_W   = $clog2(DEF_N_W);
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int D_W = 8
) (
  input  logic [D_W:0]   i_rem,
  input  logic           i_bit,
  input  logic [D_W-1:0] i_div,
  output logic [D_W:0]   o_rem,
  output logic           o_q
);
  logic [D_W+1:0] w_shift;
  logic [D_W+1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // Extra top bit acts as the borrow/sign of the trial subtraction
  assign w_diff  = w_shift - (D_W+2)'(i_div);
  assign o_q     = ~w_diff[D_W+1];
  assign o_rem   = o_q ? w_diff[D_W:0] : w_shift[D_W:0];
endmodule

// File: rtl/multiply_divide_core.sv
// Sequential restoring divider, one quotient bit per clock.
module multiply_divide_core
  import muldiv_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           dbz
);
  localparam int CW = $clog2(N_W);

  md_state_t      r_state;
  logic [CW-1:0]  r_cnt;
  logic [N_W-1:0] r_dvd;
  logic [D_W-1:0] r_div;
  logic [D_W:0]   r_rem;
  logic           r_busy;
  logic           r_done;
  logic [N_W-1:0] r_quo;
  logic [D_W-1:0] r_rmd;
  logic           r_dbz;

  logic [D_W:0]   w_nrem;
  logic           w_q;

  div_step #(.D_W(D_W)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[N_W-1]),
    .i_div (r_div),
    .o_rem (w_nrem),
    .o_q   (w_q)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_dvd   <= dividend;
              r_div   <= divisor;
              r_rem   <= '0;
              r_cnt   <= CW'(N_W-1);
              r_busy  <= 1'b1;
              r_state <= CALC;
            end else begin
              r_quo   <= '1;
              r_rmd   <= dividend[D_W-1:0];
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        CALC: begin
          r_dvd <= {r_dvd[N_W-2:0], w_q};
          r_rem <= w_nrem;
          if (r_cnt == '0) begin
            r_quo   <= {r_dvd[N_W-2:0], w_q};
            r_rmd   <= w_nrem[D_W-1:0];
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rmd;
  assign dbz       = r_dbz;
endmodule

// File: doc/multiply_divide_core.md
# multiply_divide_core

Sequential restoring divider: the inverse operation to the team's 8x8 multiply-accumulate core. It takes a 16-bit dividend (for example a product or an accumulated result) and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder, producing one quotient bit per clock. It sits inside the padded chip core beside the multiply-add datapath and uses a start/done handshake toward core control logic.

## Interface
- `N_W`, default 16: dividend and quotient width.
- `D_W`, default 8: divisor and remainder width.
- `clk` input, 1: single rising-edge clock.
- `reset` input, 1: synchronous, active-high.
- `start` input, 1: request a division; sampled only in IDLE.
- `dividend` input, N_W: unsigned; captured on the accepted start.
- `divisor` input, D_W: unsigned; captured on the accepted start.
- `busy` output, 1: high while in CALC.
- `done` output, 1: one-cycle pulse; results valid from this cycle on.
- `quotient` output, N_W: registered; held until the next accepted start.
- `remainder` output, D_W: registered; held until the next accepted start.
- `dbz` output, 1: divide-by-zero flag; held with the results.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1 and `divisor`≠0: capture both operands, clear the partial remainder, set the bit counter to N_W-1, go to CALC.
  - `start`=1 and `divisor`=0: `quotient`=all ones, `remainder`=`dividend[D_W-1:0]`, `dbz`=1, go to DONE.
- **CALC**, one restoring step per cycle, MSB first:
  - Shift the partial remainder left by one, bringing in the next dividend bit.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
  - The partial remainder is D_W+1 bits wide so the shifted value never overflows.
  - When the counter reaches 0: write `quotient`/`remainder`, clear `dbz`, go to DONE.
- **DONE**: `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- `start` outside IDLE (in CALC or DONE) is ignored; no queuing.
- Operand inputs are don't-care except on the accepted-start edge.
- Output registers change only on the DONE-entry edge or on reset.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `dbz`=0, counter=0.
- Normal latency: start accepted at edge k; CALC steps at edges k+1..k+N_W; `done` high in the cycle after edge k+N_W.
  - That is N_W+1 cycles from start to done: 17 with the defaults.
- Divide-by-zero latency: `done` high in the cycle after edge k, i.e. 1 cycle.
- `busy` rises after edge k and falls after edge k+N_W.
- Throughput: the next start can be accepted in the IDLE cycle after DONE. Back-to-back period is N_W+2 cycles.
- Reset asserted in any state, including mid-CALC or simultaneous with `start`: reset wins. Next cycle is IDLE with all outputs at reset values, and no `done` for the aborted operation.

## Structure
- Package `muldiv_pkg`:
  - state enum (IDLE/CALC/DONE);
  - default width constants N_W=16, D_W=8;
  - counter width `$clog2(N_W)`.
- One combinational sub-module, `div_step`:
  - inputs: partial remainder, incoming dividend bit, divisor;
  - outputs: next partial remainder, quotient bit.
- The FSM, counter and registers live in `multiply_divide_core`.

## Test plan
- 1000 / 7 → `quotient`=142, `remainder`=6, `dbz`=0; `done` exactly 17 cycles after start; `busy` high for 16 cycles.
- 65025 / 255 (the 255×255 product) → `quotient`=255, `remainder`=0. Also 0xFFFF / 1 → 0xFFFF, 0.
- 5 / 0 → `dbz`=1, `quotient`=0xFFFF, `remainder`=5, `done` 1 cycle after start, `busy` never asserted.
- 100 / 200 → `quotient`=0, `remainder`=100. Then 0 / 3 → 0, 0.
- `start` pulsed with 50 / 3 at cycle 5 of a 1000 / 7 run → ignored; only 142 r 6 is reported, with a single `done`.
- Reset at cycle 8 of CALC → IDLE next cycle, all outputs 0, no `done`. A following 9 / 2 completes normally as 4 r 1.
